rvh_l1d_ptw_req_arbiter: RTL

RVH_L1D_PTW_REQ_ARBITER -- requirements
Module: rvh_l1d_ptw_req_arbiter

---
 rtl/rvh_l1d_pkg.sv | 17 +
 rtl/rvh_l1d_rr_arbiter.sv | 50 +++++
 rtl/rvh_l1d_ptw_req_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rvh_l1d_pkg.sv
// ----------------------------------------------------------------------------
// rvh_l1d_pkg
// Shared definitions for the L1D page-table-walker request path.
//   walker_state_e : per-walker tracking state (IDLE / OUTSTANDING)
//   PTW_ID_WIDTH   : walker id width for the default two-walker configuration
// ----------------------------------------------------------------------------
package rvh_l1d_pkg;

    typedef enum logic {
        WALKER_IDLE        = 1'b0,
        WALKER_OUTSTANDING = 1'b1
    } walker_state_e;

    localparam int PTW_REQ_NUM_DEFAULT = 2;
    localparam int PTW_ID_WIDTH        = $clog2(PTW_REQ_NUM_DEFAULT);

endpackage

// File: rtl/rvh_l1d_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rvh_l1d_rr_arbiter
// N-way round-robin pick. The 1-hot pointer marks the highest-priority
// requester; priority then descends in increasing index order with wrap.
// N must be a power of two so index arithmetic wraps naturally.
// Ports:
//   req       in  N      : request vector
//   ptr       in  N      : 1-hot priority pointer
//   grant     out N      : 1-hot grant (zero when no request)
//   grant_idx out log2 N : binary index of the granted requester
//   any       out 1      : at least one request present
// ----------------------------------------------------------------------------
module rvh_l1d_rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] idx;

    // Convert the 1-hot pointer to an index, then walk the requesters starting
    // there; the first active one wins.
    always_comb begin
        base      = '0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) begin
                base = IDX_W'(i);
            end
        end
        for (int k = 0; k < N; k++) begin
            idx = base + IDX_W'(k);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvh_l1d_ptw_req_arbiter.sv
// ----------------------------------------------------------------------------
// rvh_l1d_ptw_req_arbiter
// Shares one L1D PTW request/response port between REQ_NUM page-table walkers
// plus a replay buffer. Each walker may have one request outstanding; new
// requests are picked round-robin, replays re-issue on behalf of an
// outstanding walker, and responses are routed back by id.
// Configuration macro:
//   RVH_L1D_PTW_ARB_REPLAY_PRIO_EN : eligible replay always beats new requests.
//   Undefined (default)            : a 1-bit toggle alternates replay vs new
//                                    whenever both contend.
// Ports:
//   clk, rst                               : clock, synchronous active-high reset
//   walker_req_vld_i/paddr_i, _rdy_o       : per-walker new request
//   replay_vld_i/id_i/paddr_i, replay_rdy_o: replay request
//   l1d_req_vld_o/id_o/paddr_o, _rdy_i     : shared L1D request port
//   l1d_resp_vld_i/id_i, l1d_resp_rdy_o    : shared L1D response port
//   walker_resp_vld_o, walker_resp_rdy_i   : routed per-walker responses
//   walker_busy_o                          : walker has a request outstanding
// ----------------------------------------------------------------------------
module rvh_l1d_ptw_req_arbiter
    import rvh_l1d_pkg::*;
#(
    parameter  int REQ_NUM     = 2,
    parameter  int PADDR_WIDTH = 56,
    localparam int ID_W        = $clog2(REQ_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_NUM-1:0]             walker_req_vld_i,
    input  logic [REQ_NUM*PADDR_WIDTH-1:0] walker_req_paddr_i,
    output logic [REQ_NUM-1:0]             walker_req_rdy_o,
    input  logic                           replay_vld_i,
    input  logic [ID_W-1:0]                replay_id_i,
    input  logic [PADDR_WIDTH-1:0]         replay_paddr_i,
    output logic                           replay_rdy_o,
    output logic                           l1d_req_vld_o,
    output logic [ID_W-1:0]                l1d_req_id_o,
    output logic [PADDR_WIDTH-1:0]         l1d_req_paddr_o,
    input  logic                           l1d_req_rdy_i,
    input  logic                           l1d_resp_vld_i,
    input  logic [ID_W-1:0]                l1d_resp_id_i,
    output logic                           l1d_resp_rdy_o,
    output logic [REQ_NUM-1:0]             walker_resp_vld_o,
    input  logic [REQ_NUM-1:0]             walker_resp_rdy_i,
    output logic [REQ_NUM-1:0]             walker_busy_o
);

    walker_state_e      state_q [REQ_NUM];
    logic [REQ_NUM-1:0] busy;
    logic [REQ_NUM-1:0] rr_ptr_q;
    logic [REQ_NUM-1:0] new_req;
    logic [REQ_NUM-1:0] new_grant;
    logic [ID_W-1:0]    new_idx;
    logic               new_any;
    logic               resp_to_busy;
    logic               resp_hs;
    logic               replay_elig;
    logic               sel_replay;
    logic               sel_new;
    logic               new_hs;

    // Flatten the per-walker state into a busy vector.
    always_comb begin
        busy = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            busy[i] = (state_q[i] == WALKER_OUTSTANDING);
        end
    end

    assign walker_busy_o = busy;
    assign new_req       = walker_req_vld_i & ~busy;

    rvh_l1d_rr_arbiter #(
        .N (REQ_NUM)
    ) u_rr_arbiter (
        .req       (new_req),
        .ptr       (rr_ptr_q),
        .grant     (new_grant),
        .grant_idx (new_idx),
        .any       (new_any)
    );

    // Responses to an idle walker (e.g. stale after reset) are swallowed.
    assign resp_to_busy   = busy[l1d_resp_id_i];
    assign l1d_resp_rdy_o = resp_to_busy ? walker_resp_rdy_i[l1d_resp_id_i] : 1'b1;
    assign resp_hs        = l1d_resp_vld_i & resp_to_busy & walker_resp_rdy_i[l1d_resp_id_i];

    always_comb begin
        walker_resp_vld_o = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            walker_resp_vld_o[i] = l1d_resp_vld_i & resp_to_busy & (l1d_resp_id_i == ID_W'(i));
        end
    end

    // A replay for a walker whose response is retiring this cycle is stale.
    assign replay_elig = replay_vld_i & busy[replay_id_i]
                       & ~(resp_hs & (l1d_resp_id_i == replay_id_i));

`ifdef RVH_L1D_PTW_ARB_REPLAY_PRIO_EN
    assign sel_replay = replay_elig;
`else
    logic prio_q;

    assign sel_replay = replay_elig & (~new_any | prio_q);

    // Flip replay-vs-new priority after every contended handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (replay_elig & new_any & l1d_req_rdy_i) begin
            prio_q <= ~prio_q;
        end
    end
`endif

    assign sel_new          = new_any & ~sel_replay;
    assign new_hs           = sel_new & l1d_req_rdy_i;
    assign l1d_req_vld_o    = replay_elig | new_any;
    assign l1d_req_id_o     = sel_replay ? replay_id_i : new_idx;
    assign l1d_req_paddr_o  = sel_replay ? replay_paddr_i
                                         : walker_req_paddr_i[new_idx*PADDR_WIDTH +: PADDR_WIDTH];
    assign walker_req_rdy_o = new_grant & {REQ_NUM{new_hs}};
    assign replay_rdy_o     = ~replay_elig | (sel_replay & l1d_req_rdy_i);

    // Walker state and round-robin pointer; the pointer rotates one past the
    // walker just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                state_q[i] <= WALKER_IDLE;
            end
            rr_ptr_q <= REQ_NUM'(1);
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (new_hs && new_grant[i]) begin
                    state_q[i] <= WALKER_OUTSTANDING;
                end else if (resp_hs && (l1d_resp_id_i == ID_W'(i))) begin
                    state_q[i] <= WALKER_IDLE;
                end
            end
            if (new_hs) begin
                rr_ptr_q <= {new_grant[REQ_NUM-2:0], new_grant[REQ_NUM-1]};
            end
        end
    end

endmodule
